regfile_writeback_stage: RTL

- Registered write-back stage that drives the RegFile's single write port.
- Primary source: the in-order pipeline. It selects the destination (rt, rd or link register), extracts sign/zero-extended bytes or halfwords from load data, routes LO/HI, or passes the ALU result.
- Secondary source: a FIFO of late results from multi-cycle units (mul/div, future coprocessors). These are merged into the same write port with WAW-safe ordering.
- Sits between MEM and RegFile and replaces the purely combinational write-data selection.

---
 rtl/wb_pkg.sv | 44 ++++
 rtl/regfile_writeback_stage_late_fifo.sv | 75 +++++++
 rtl/regfile_writeback_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared encodings and load-extraction helper
// for the register-file write-back stage.
package wb_pkg;

   // Widest datapath the load extractor handles.
   localparam int WB_MAX_BITS = 64;

   typedef enum logic [1:0] {
      EXTR_WORD  = 2'd0,
      EXTR_BYTE  = 2'd1,
      EXTR_HALF  = 2'd2,
      EXTR_UNDEF = 2'd3
   } extr_e;

   typedef enum logic [1:0] {
      LH_NONE  = 2'd0,
      LH_LO    = 2'd1,
      LH_HI    = 2'd2,
      LH_UNDEF = 2'd3
   } lh_sel_e;

   // Byte lane addr_byte, halfword lane addr_byte[1].
   function automatic logic [WB_MAX_BITS-1:0] extract_load(
      input logic [WB_MAX_BITS-1:0] word,
      input logic [1:0]             addr_byte,
      input extr_e                  mode,
      input logic                   sgn
   );
      logic [7:0]             b;
      logic [15:0]            h;
      logic [WB_MAX_BITS-1:0] r;
      b = word[{addr_byte, 3'b000} +: 8];
      h = word[{addr_byte[1], 4'b0000} +: 16];
      r = '0;
      case (mode)
         EXTR_WORD: r = word;
         EXTR_BYTE: r = {{(WB_MAX_BITS-8){sgn & b[7]}}, b};
         EXTR_HALF: r = {{(WB_MAX_BITS-16){sgn & h[15]}}, h};
         default:   r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/regfile_writeback_stage_late_fifo.sv
// Late-result FIFO: {idx,data} entries from multi-cycle
// units, with an any-entry index match for WAW checks.
module late_result_fifo
   import wb_pkg::*;
#(
   parameter int IDX_BITS  = 5,
   parameter int DATA_BITS = 32,
   parameter int DEPTH     = 4,
   localparam int PTR_BITS = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [IDX_BITS-1:0]  push_idx,
   input  logic [DATA_BITS-1:0] push_data,
   input  logic                 pop,
   output logic [IDX_BITS-1:0]  head_idx,
   output logic [DATA_BITS-1:0] head_data,
   output logic                 full,
   output logic                 empty,
   output logic [PTR_BITS:0]    count,
   input  logic [IDX_BITS-1:0]  query_idx,
   output logic                 match_any
);

   logic [IDX_BITS-1:0]  idx_mem  [DEPTH];
   logic [DATA_BITS-1:0] data_mem [DEPTH];
   logic [PTR_BITS-1:0]  wr_ptr;
   logic [PTR_BITS-1:0]  rd_ptr;
   logic [DEPTH-1:0]     match;
   logic                 push_ok;
   logic                 pop_ok;

   assign full      = (count == (PTR_BITS+1)'(DEPTH));
   assign empty     = (count == '0);
   assign push_ok   = push & ~full;
   assign pop_ok    = pop & ~empty;
   assign head_idx  = idx_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];
   assign match_any = |match;

   // An entry is live when its distance from the head is below count.
   for (genvar g = 0; g < DEPTH; g++) begin : g_match
      logic [PTR_BITS-1:0] offs;
      assign offs     = PTR_BITS'(g) - rd_ptr;
      assign match[g] = ({1'b0, offs} < count) &&
                        (idx_mem[g] == query_idx);
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents only matter while counted as live.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         idx_mem[wr_ptr]  <= push_idx;
         data_mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/regfile_writeback_stage.sv
// Registered write-back stage: merges in-order pipeline
// results and late multi-cycle results onto one RegFile port.
module regfile_writeback_stage
   import wb_pkg::*;
#(
   parameter int DATA_BITS    = 32,
   parameter int REG_IDX_BITS = 5,
   parameter int LINK_REG     = 31,
   parameter int LATE_DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_reg_write,
   input  logic [REG_IDX_BITS-1:0] in_rt,
   input  logic [REG_IDX_BITS-1:0] in_rd,
   input  logic                    in_reg_dst,
   input  logic                    in_jal,
   input  logic [DATA_BITS-1:0]    in_pc,
   input  logic [DATA_BITS-1:0]    in_alu_out,
   input  logic                    in_mem_to_reg,
   input  logic [DATA_BITS-1:0]    in_mem_out,
   input  logic [1:0]              in_addr_byte,
   input  logic [1:0]              in_extr_word,
   input  logic                    in_extr_signed,
   input  logic [1:0]              in_lh_to_reg,
   input  logic [DATA_BITS-1:0]    in_lo,
   input  logic [DATA_BITS-1:0]    in_hi,
   input  logic                    late_valid,
   output logic                    late_ready,
   input  logic [REG_IDX_BITS-1:0] late_idx,
   input  logic [DATA_BITS-1:0]    late_data,
   output logic                    wb_we,
   output logic [REG_IDX_BITS-1:0] wb_w,
   output logic [DATA_BITS-1:0]    wb_din,
   output logic [$clog2(LATE_DEPTH):0] late_count
);

   logic [REG_IDX_BITS-1:0] w_sel;
   logic [DATA_BITS-1:0]    din_sel;
   logic [DATA_BITS-1:0]    load_val;
   logic [REG_IDX_BITS-1:0] head_idx;
   logic [DATA_BITS-1:0]    head_data;
   logic                    full;
   logic                    empty;
   logic                    match_any;
   logic                    late_push;
   logic                    hazard;
   logic                    accept;
   logic                    pop;

   assign load_val = DATA_BITS'(extract_load(
      WB_MAX_BITS'(in_mem_out), in_addr_byte,
      extr_e'(in_extr_word), in_extr_signed));

   // Destination index and write data for the pipeline op.
   always_comb begin
      w_sel   = in_reg_dst ? in_rd : in_rt;
      din_sel = in_alu_out;
      priority case (1'b1)
         in_jal: begin
            w_sel   = REG_IDX_BITS'(LINK_REG);
            din_sel = in_pc;
         end
         in_mem_to_reg: din_sel = load_val;
         default: begin
            case (lh_sel_e'(in_lh_to_reg))
               LH_LO:    din_sel = in_lo;
               LH_HI:    din_sel = in_hi;
               LH_UNDEF: din_sel = '0;
               default:  din_sel = in_alu_out;
            endcase
         end
      endcase
   end

   // An older late result to the same register must land first.
   assign late_ready = ~rst & ~full;
   assign late_push  = late_valid & late_ready;
   assign hazard     = in_reg_write & (w_sel != '0) &
                       (match_any | (late_push & (late_idx == w_sel)));
   assign in_ready   = ~rst & ~full & ~hazard;
   assign accept     = in_valid & in_ready;
   assign pop        = ~rst & ~accept & ~empty;

   late_result_fifo #(
      .IDX_BITS  (REG_IDX_BITS),
      .DATA_BITS (DATA_BITS),
      .DEPTH     (LATE_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (late_push),
      .push_idx  (late_idx),
      .push_data (late_data),
      .pop       (pop),
      .head_idx  (head_idx),
      .head_data (head_data),
      .full      (full),
      .empty     (empty),
      .count     (late_count),
      .query_idx (w_sel),
      .match_any (match_any)
   );

   // Write-port slot: pipeline op wins, else FIFO head drains.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_we  <= 1'b0;
         wb_w   <= '0;
         wb_din <= '0;
      end else if (accept) begin
         wb_we  <= in_reg_write & (w_sel != '0);
         wb_w   <= w_sel;
         wb_din <= din_sel;
      end else if (!empty) begin
         wb_we  <= (head_idx != '0);
         wb_w   <= head_idx;
         wb_din <= head_data;
      end else begin
         wb_we  <= 1'b0;
      end
   end

endmodule
